aes_key_sched_ctrl: RTL and testbench
=====================================

// Module: aes_key_sched_ctrl
// PURPOSE
//  Iterative AES-128 key-expansion controller. Accepts a 128-bit cipher key and streams round keys 0..NUM_ROUNDS.
//  One round-key step per cycle: RotWord/SubWord on w3, Rcon XOR, then the XOR chain.
//  Sits between the key input and the round datapath. The cipher core pulls round keys over a valid/ready stream.
// PARAMETERS
//  NUM_ROUNDS  10  number of expansion rounds; round keys 0..NUM_ROUNDS are emitted (AES-128 only)
// PORTS
//  clk        in   1    single clock; all state on rising edge
//  rst        in   1    asynchronous, active-high reset
//  start      in   1    request expansion; accepted only in IDLE
//  key_in     in   128  cipher key, [127:96]=w0 .. [31:0]=w3; sampled on accepted start
//  busy       out  1    high from the cycle after start is accepted until done
//  rk_valid   out  1    round key on rk_data is valid
//  rk_ready   in   1    consumer accepts round key (handshake = rk_valid & rk_ready)
//  rk_data    out  128  current round key, same word order as key_in
//  rk_round   out  4    index of round key on rk_data (0..NUM_ROUNDS)
//  done       out  1    one-cycle pulse after final round key handshake
//  rd_idx     in   4    KEY_STORE_EN readback index
//  rd_data    out  128  KEY_STORE_EN readback data
// BEHAVIOUR
//  Reset: state=IDLE. busy, rk_valid and done are 0. rk_data, rk_round, rd_data and rcon are 0. Storage contents are don't-care.
//  FSM: IDLE -start-> EMIT. EMIT -handshake & rk_round<NUM_ROUNDS-> EMIT (next key). EMIT -handshake & rk_round==NUM_ROUNDS-> DONE. DONE -> IDLE (1 cycle, done=1).
//  Accept cycle T: key_in is registered into rk_data, and rk_round=0. rk_valid=1 and busy=1 from T+1.
//  On each handshake with rk_round<NUM_ROUNDS, the next cycle holds:
//    - rk_data = next round key
//    - rk_round = rk_round+1
//    - rk_valid stays 1
//  With rk_ready tied 1, keys 0..10 appear on cycles T+1..T+11, and done=1 at T+12.
//  Backpressure: while rk_valid & !rk_ready, rk_data and rk_round hold stable. No expansion step occurs.
//  Next-key step (combinational from rk_data):
//    - t = SubWord(RotWord(w3)) ^ {rcon,24'h0}
//    - w0' = w0^t, w1' = w1^w0', w2' = w2^w1', w3' = w3^w2'
//  RotWord: bytes [b0 b1 b2 b3] -> [b1 b2 b3 b0], where b0 is the MSB byte. SubWord: forward AES S-box per byte.
//  Rcon register: 8'h01 on accept. Updates to xtime(rcon) on each step (01,02,04..80,1B,36). xtime = {r[6:0],1'b0} ^ (r[7] ? 8'h1B : 0).
//  start while busy (EMIT or DONE): ignored. key_in is not resampled.
//  start in IDLE in the same cycle as the done pulse is not possible. DONE lasts one cycle, and start is accepted on the following IDLE cycle.
//  Reset asserted mid-expansion: immediate return to reset values. No done pulse. The partial sequence is discarded.
//  rk_valid drops to 0 in the DONE cycle. busy drops to 0 in the DONE cycle.
// CONFIGURATION
//  KEY_STORE_EN defined:
//    - (NUM_ROUNDS+1)x128 register array. Entry rk_round is written on every handshake.
//    - rd_data = array[rd_idx], a combinational read.
//    - rd_idx>NUM_ROUNDS returns 0.
//    - Entries are valid for reading once done has pulsed, and stay valid until the next accepted start.
//  KEY_STORE_EN undefined: no array. rd_data is tied to 0 and rd_idx is unused. The ports remain so the port list is identical.
// STRUCTURE
//  Shared package aes_pkg:
//    - AES_NR_128=10 constant
//    - word_t (32-bit) and key128_t typedefs
//    - xtime function
//    - forward S-box function/table (shared with the round datapath)
//  Sub-module key_round_step (combinational): rk_data, rcon -> next round key. Holds RotWord, 4 S-box lookups, and the XOR chain.
//  Top: FSM, round counter, rcon register, rk_data register, and the optional store.
// TESTING
//  1 FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1:
//      - rk0=key
//      - rk1=a0fafe1788542cb123a339392a6c7605
//      - rk10=d014f9a8c9ee2589e13f0cc8b6630ca6
//      - done at T+12
//  2 All-zero key: rk1=62636363626363636263636362636363, rk10=b4ef5bcb3e92e21123e951cf6f8f188e.
//  3 Random rk_ready (~30% duty) on vector 1: identical key sequence. rk_data/rk_round are stable during stalls. 11 handshakes exactly.
//  4 start pulsed during EMIT with a different key_in: ignored. The sequence continues with the original key. busy stays 1.
//  5 rst asserted at rk_round=5: next edge-independent outputs go to 0. A new start then reproduces vector 1 from rk0 (rcon restarts at 01).
//  6 KEY_STORE_EN defined, after vector 1: rd_idx=1 -> a0fafe17..7605, rd_idx=10 -> d014..0ca6, rd_idx=15 -> 0. Undefined: rd_data always 0.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES package.
//   AES_NR_128   number of AES-128 rounds
//   word_t       32-bit key word, key128_t 128-bit key / round key
//   ks_state_e   key-schedule controller states
//   xtime()      multiply by x in GF(2^8)
//   sbox()       forward AES S-box (also used by the round datapath)
package aes_pkg;

  localparam int AES_NR_128 = 10;

  typedef logic [31:0]  word_t;
  typedef logic [127:0] key128_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EMIT,
    ST_DONE
  } ks_state_e;

  // Row-major forward S-box; element 0 sits in the most significant byte.
  localparam logic [0:255][7:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TABLE[b];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] r);
    return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_key_sched_ctrl_if.sv
// Key-schedule stream interface.
//   master: cipher-core side (drives start/key_in/rk_ready/rd_idx)
//   slave : key-schedule controller side
interface aes_key_sched_ctrl_if;

  logic                  start;
  aes_pkg::key128_t      key_in;
  logic                  busy;
  logic                  rk_valid;
  logic                  rk_ready;
  aes_pkg::key128_t      rk_data;
  logic [3:0]            rk_round;
  logic                  done;
  logic [3:0]            rd_idx;
  aes_pkg::key128_t      rd_data;

  modport master (
    output start, key_in, rk_ready, rd_idx,
    input  busy, rk_valid, rk_data, rk_round, done, rd_data
  );

  modport slave (
    input  start, key_in, rk_ready, rd_idx,
    output busy, rk_valid, rk_data, rk_round, done, rd_data
  );

endinterface

// File: rtl/aes_key_sched_ctrl_key_round_step.sv
// key_round_step: combinational AES-128 key-expansion step.
//   rk_in  : current round key, [127:96]=w0 .. [31:0]=w3
//   rcon   : round constant for this step
//   rk_out : next round key, same word order
module key_round_step
  import aes_pkg::*;
(
  input  key128_t    rk_in,
  input  logic [7:0] rcon,
  output key128_t    rk_out
);

  word_t w0, w1, w2, w3;
  word_t rot, t;
  word_t n0, n1, n2, n3;

  always_comb begin
    {w0, w1, w2, w3} = rk_in;
    // RotWord: the most significant byte moves to the bottom.
    rot = {w3[23:0], w3[31:24]};
    t   = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])}
          ^ {rcon, 24'h0};
    n0  = w0 ^ t;
    n1  = w1 ^ n0;
    n2  = w2 ^ n1;
    n3  = w3 ^ n2;
    rk_out = {n0, n1, n2, n3};
  end

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// aes_key_sched_ctrl: iterative AES-128 key-expansion controller.
// Accepts a cipher key on start and streams round keys 0..NUM_ROUNDS over a
// valid/ready handshake, one expansion step per accepted key.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : aes_key_sched_ctrl_if.slave (start/key_in, rk_* stream,
//              busy, done, rd_idx/rd_data readback)
// Optional macro KEY_STORE_EN: keeps every emitted round key in a register
// array readable through rd_idx/rd_data; otherwise rd_data is tied to 0.
module aes_key_sched_ctrl
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = AES_NR_128
) (
  input logic                 clk,
  input logic                 rst,
  aes_key_sched_ctrl_if.slave bus
);

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

  ks_state_e  state_q, state_d;
  logic       busy_q, busy_d;
  logic       rk_valid_q, rk_valid_d;
  logic       done_q, done_d;
  key128_t    rk_data_q, rk_data_d;
  logic [3:0] rk_round_q, rk_round_d;
  logic [7:0] rcon_q, rcon_d;

  key128_t    next_key;
  logic       handshake;

  assign handshake = rk_valid_q & bus.rk_ready;

  key_round_step u_step (
    .rk_in  (rk_data_q),
    .rcon   (rcon_q),
    .rk_out (next_key)
  );

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned; that is what keeps always_comb from inferring latches.
  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    rk_valid_d = rk_valid_q;
    done_d     = 1'b0;
    rk_data_d  = rk_data_q;
    rk_round_d = rk_round_q;
    rcon_d     = rcon_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d    = ST_EMIT;
          busy_d     = 1'b1;
          rk_valid_d = 1'b1;
          rk_data_d  = bus.key_in;
          rk_round_d = '0;
          rcon_d     = 8'h01;
        end
      end
      ST_EMIT: begin
        // Stalled cycles change nothing: the key and index hold until taken.
        if (handshake) begin
          if (rk_round_q == LAST_ROUND) begin
            state_d    = ST_DONE;
            busy_d     = 1'b0;
            rk_valid_d = 1'b0;
            done_d     = 1'b1;
          end else begin
            rk_data_d  = next_key;
            rk_round_d = rk_round_q + 4'd1;
            rcon_d     = xtime(rcon_q);
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: non-blocking assignments here so every flop samples the values of
  // the previous cycle regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      busy_q     <= 1'b0;
      rk_valid_q <= 1'b0;
      done_q     <= 1'b0;
      rk_data_q  <= '0;
      rk_round_q <= '0;
      rcon_q     <= '0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      rk_valid_q <= rk_valid_d;
      done_q     <= done_d;
      rk_data_q  <= rk_data_d;
      rk_round_q <= rk_round_d;
      rcon_q     <= rcon_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.rk_valid = rk_valid_q;
  assign bus.done     = done_q;
  assign bus.rk_data  = rk_data_q;
  assign bus.rk_round = rk_round_q;

`ifdef KEY_STORE_EN
  key128_t key_store_q [0:NUM_ROUNDS];

  // NOTE: the store is reset along with the control state so rd_data reads 0
  // out of reset instead of X; contents only matter after done anyway.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i <= NUM_ROUNDS; i++) key_store_q[i] <= '0;
    end else if (handshake) begin
      key_store_q[rk_round_q] <= rk_data_q;
    end
  end

  assign bus.rd_data = (bus.rd_idx <= LAST_ROUND) ? key_store_q[bus.rd_idx] : '0;
`else
  logic unused_rd_idx;
  assign unused_rd_idx = ^bus.rd_idx;
  assign bus.rd_data   = '0;
`endif

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Self-checking bench for aes_key_sched_ctrl. The reference key expansion is
// computed from FIPS-197 word arithmetic with an S-box derived from GF(2^8)
// inversion plus the affine map, independent of the RTL tables.
module tb_aes_key_sched_ctrl;

  localparam int NR = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  aes_key_sched_ctrl_if bus ();

  aes_key_sched_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [7:0]   model_sbox [0:255];
  logic [127:0] exp_rk     [0:NR];
  logic [127:0] got_rk     [0:NR];

  localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_RK1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      logic [7:0] xb  = 8'(x);
      if (x != 0)
        for (int y = 1; y < 256; y++)
          if (gmul(xb, 8'(y)) == 8'h01) inv = 8'(y);
      model_sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                      ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic model_expand(input logic [127:0] key);
    logic [31:0] w [0:4*NR+3];
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 4 * (NR + 1); i++) begin
      logic [31:0] temp = w[i-1];
      if (i % 4 == 0) begin
        temp = {temp[23:0], temp[31:24]};
        temp = {model_sbox[temp[31:24]], model_sbox[temp[23:16]],
                model_sbox[temp[15:8]], model_sbox[temp[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ temp;
    end
    for (int r = 0; r <= NR; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // ---------------- stimulus engine ----------------
  // Runs one expansion. ready_pct: rk_ready duty; glitch_cyc: cycle after
  // accept where a second start with another key is pulsed (-1 none);
  // abort_k: round index at which rst is asserted (-1 none).
  task automatic run_expansion(input logic [127:0] key, input int ready_pct,
                               input int glitch_cyc, input int abort_k,
                               output int hs, output int done_cyc);
    int k = 0;
    int cyc = 0;
    bit finished = 0;
    model_expand(key);
    done_cyc = -1;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.key_in = key;
    @(posedge clk);
    @(negedge clk);
    bus.start  = 1'b0;
    bus.key_in = ~key;
    while (!finished && cyc < 500) begin
      if (cyc != 0) @(negedge clk);
      cyc++;
      bus.start = (cyc == glitch_cyc);
      if (k == NR + 1) begin
        checks++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.rk_valid !== 1'b0) begin
          failures++;
          $display("FAIL done_cycle: done=%b busy=%b rk_valid=%b, required 1/0/0", bus.done, bus.busy, bus.rk_valid);
        end
        done_cyc = cyc;
        finished = 1;
      end else begin
        checks++;
        if (bus.rk_valid !== 1'b1 || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
          failures++;
          $display("FAIL emit_flags k=%0d: rk_valid=%b busy=%b done=%b, required 1/1/0", k, bus.rk_valid, bus.busy, bus.done);
        end
        checks++;
        if (bus.rk_data !== exp_rk[k] || bus.rk_round !== 4'(k)) begin
          failures++;
          $display("FAIL rk k=%0d: data=%h round=%0d, required %h %0d", k, bus.rk_data, bus.rk_round, exp_rk[k], k);
        end
        got_rk[k] = bus.rk_data;
        if (k == abort_k) begin
          bus.rk_ready = 1'b0;
          rst = 1'b1;
          #1;
          checks++;
          if (bus.busy !== 1'b0 || bus.rk_valid !== 1'b0 || bus.done !== 1'b0 ||
              bus.rk_data !== '0 || bus.rk_round !== 4'd0) begin
            failures++;
            $display("FAIL abort_reset: busy=%b valid=%b done=%b data=%h round=%0d, required all 0",
                     bus.busy, bus.rk_valid, bus.done, bus.rk_data, bus.rk_round);
          end
          @(negedge clk);
          rst = 1'b0;
          hs = k;
          return;
        end
        bus.rk_ready = ($urandom_range(99) < 32'(ready_pct));
        if (bus.rk_ready) k++;
      end
    end
    bus.rk_ready = 1'b0;
    bus.start    = 1'b0;
    hs = k;
    if (!finished) begin
      checks++;
      failures++;
      $display("FAIL timeout: no done after %0d cycles, handshakes=%0d", cyc, k);
      return;
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL done_pulse_width: done=%b busy=%b after pulse, required 0/0", bus.done, bus.busy);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0; bus.key_in = '0; bus.rk_ready = 1'b0; bus.rd_idx = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.rk_valid !== 1'b0 || bus.done !== 1'b0 ||
        bus.rk_data !== '0 || bus.rk_round !== 4'd0 || bus.rd_data !== '0) begin
      failures++;
      $display("FAIL reset: busy=%b valid=%b done=%b data=%h round=%0d rd=%h, required all 0",
               bus.busy, bus.rk_valid, bus.done, bus.rk_data, bus.rk_round, bus.rd_data);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_known_vector(input logic [127:0] key, input logic [127:0] rk1,
                                   input logic [127:0] rk10, input string name);
    int hs, dc;
    run_expansion(key, 100, -1, -1, hs, dc);
    checks++;
    if (got_rk[0] !== key || got_rk[1] !== rk1 || got_rk[10] !== rk10) begin
      failures++;
      $display("FAIL %s_known: rk0=%h rk1=%h rk10=%h, required %h %h %h", name,
               got_rk[0], got_rk[1], got_rk[10], key, rk1, rk10);
    end
    checks++;
    if (dc !== 12 || hs !== NR + 1) begin
      failures++;
      $display("FAIL %s_timing: done at T+%0d hs=%0d, required T+12 hs=11", name, dc, hs);
    end
  endtask

  task automatic test_backpressure();
    int hs, dc;
    run_expansion(FIPS_KEY, 30, -1, -1, hs, dc);
    checks++;
    if (hs !== NR + 1 || dc < 12) begin
      failures++;
      $display("FAIL backpressure: hs=%0d done at T+%0d, required hs=11 done>=T+12", hs, dc);
    end
  endtask

  task automatic test_start_ignored();
    int hs, dc;
    run_expansion(FIPS_KEY, 100, 4, -1, hs, dc);
    checks++;
    if (got_rk[10] !== FIPS_RK10 || dc !== 12) begin
      failures++;
      $display("FAIL start_ignored: rk10=%h done at T+%0d, required %h T+12", got_rk[10], dc, FIPS_RK10);
    end
  endtask

  task automatic test_reset_abort();
    int hs, dc;
    run_expansion(FIPS_KEY, 100, -1, 5, hs, dc);
    test_known_vector(FIPS_KEY, FIPS_RK1, FIPS_RK10, "post_abort");
  endtask

  task automatic test_random_keys();
    int hs, dc;
    for (int n = 0; n < 4; n++) begin
      logic [127:0] key = {$urandom, $urandom, $urandom, $urandom};
      run_expansion(key, 60, -1, -1, hs, dc);
      checks++;
      if (hs !== NR + 1) begin
        failures++;
        $display("FAIL random_key%0d: hs=%0d, required 11", n, hs);
      end
    end
  endtask

  task automatic test_key_store();
    int hs, dc;
    run_expansion(FIPS_KEY, 70, -1, -1, hs, dc);
    for (int i = 0; i < 16; i++) begin
      logic [127:0] want;
`ifdef KEY_STORE_EN
      want = (i <= NR) ? exp_rk[i] : '0;
`else
      want = '0;
`endif
      bus.rd_idx = 4'(i);
      #1;
      checks++;
      if (bus.rd_data !== want) begin
        failures++;
        $display("FAIL key_store idx=%0d: rd_data=%h, required %h", i, bus.rd_data, want);
      end
    end
    bus.rd_idx = '0;
  endtask

  initial begin
    build_sbox();
    test_reset();
    test_known_vector(FIPS_KEY, FIPS_RK1, FIPS_RK10, "fips");
    test_known_vector('0, ZERO_RK1, ZERO_RK10, "zero");
    test_backpressure();
    test_start_ignored();
    test_reset_abort();
    test_random_keys();
    test_key_store();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
